axi_line_master: RTL and testbench

//  AXI4 master that turns one-line cache fill/writeback requests into INCR bursts.

---
 rtl/axi_line_master_if.sv | 79 +++++++
 rtl/axi_line_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi_line_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_line_master_if.sv
// AXI4 bus between a line master and a memory slave.
// Carries all five channels (AW, W, B, AR, R) for one master/slave pair.
//   modport master : drives AW/W/AR payload and valids, B/R readys
//   modport slave  : drives AW/W/AR readys, B/R payload and valids
// Parameters: DATA_WIDTH (bits per beat), ADDR_WIDTH (byte address), ID_WIDTH.
interface axi_line_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // write address
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  // write data
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  // write response
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  // read address
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  // read data
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_line_master.sv
// Line-granular AXI4 master: turns one cache-line fill or writeback request
// into a single INCR burst of LINE_WORDS beats, one transaction at a time.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_*_i/_o      line request (valid/ready, we, byte addr, writeback line)
//   resp_*_i/_o     completion (valid/ready, we, err, fill line)
//   m_axi           AXI4 master port (AW/W/B/AR/R)
// Line packing: word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; latches addr/we/line on accept
// AR     | arvalid high, waiting for arready
// R      | rready high, collecting read beats into the fill line
// AW     | awvalid high, waiting for awready
// W      | wvalid high, streaming writeback words
// B      | bready high, waiting for the write response
// RESP   | resp_valid high until the requester takes it
module axi_line_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int LINE_WORDS = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic                             req_we_i,
  input  logic [ADDR_WIDTH-1:0]            req_addr_i,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata_i,
  output logic                             resp_valid_o,
  input  logic                             resp_ready_i,
  output logic                             resp_we_o,
  output logic                             resp_err_o,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_rdata_o,
  axi_line_master_if.master                m_axi
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFFS_W = $clog2(LINE_WORDS * STRB_WIDTH);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((1 << OFFS_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_RESP
  } state_t;

  typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  // Writeback and fill lines are kept apart so a writeback never disturbs
  // the last fill line presented on resp_rdata.
  line_t                 wline_q, wline_d;
  line_t                 rline_q, rline_d;

  logic                  req_ready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wlast_q;
  logic                  bready_q;
  logic                  resp_valid_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    err_d   = err_q;
    beat_d  = beat_q;
    wline_d = wline_q;
    rline_d = rline_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i & ~OFFS_MASK;
          we_d    = req_we_i;
          wline_d = req_wdata_i;
          err_d   = 1'b0;
          beat_d  = '0;
          state_d = req_we_i ? S_AW : S_AR;
        end
      end

      S_AR: begin
        if (arvalid_q && m_axi.arready) begin
          beat_d  = '0;
          state_d = S_R;
        end
      end

      S_R: begin
        if (rready_q && m_axi.rvalid) begin
          rline_d[beat_q] = m_axi.rdata;
          if (m_axi.rresp != 2'b00) begin
            err_d = 1'b1;
          end
          if (m_axi.rlast) begin
            // short burst: remaining words keep their previous contents
            if (beat_q != LAST_BEAT) begin
              err_d = 1'b1;
            end
            state_d = S_RESP;
          end else if (beat_q == LAST_BEAT) begin
            // over-long burst: keep overwriting the last word until rlast
            err_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_AW: begin
        if (awvalid_q && m_axi.awready) begin
          beat_d  = '0;
          state_d = S_W;
        end
      end

      S_W: begin
        if (wvalid_q && m_axi.wready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_B;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_B: begin
        if (bready_q && m_axi.bvalid) begin
          if (m_axi.bresp != 2'b00) begin
            err_d = 1'b1;
          end
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (resp_ready_i) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state, so they always
  // mirror state_q without any combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      beat_q       <= '0;
      wline_q      <= '0;
      rline_q      <= '0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      err_q        <= err_d;
      beat_q       <= beat_d;
      wline_q      <= wline_d;
      rline_q      <= rline_d;
      req_ready_q  <= (state_d == S_IDLE);
      arvalid_q    <= (state_d == S_AR);
      rready_q     <= (state_d == S_R);
      awvalid_q    <= (state_d == S_AW);
      wvalid_q     <= (state_d == S_W);
      // beat_d only moves on a W handshake, so data/last hold under backpressure
      wdata_q      <= wline_d[beat_d];
      wlast_q      <= (beat_d == LAST_BEAT);
      bready_q     <= (state_d == S_B);
      resp_valid_q <= (state_d == S_RESP);
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_we_o    = we_q;
  assign resp_err_o   = err_q;
  assign resp_rdata_o = rline_q;

  assign m_axi.awid    = AXI_ID;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 8'(LINE_WORDS - 1);
  assign m_axi.awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0000;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;

  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast_q;
  assign m_axi.wvalid  = wvalid_q;

  assign m_axi.bready  = bready_q;

  assign m_axi.arid    = AXI_ID;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = 8'(LINE_WORDS - 1);
  assign m_axi.arsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;

  assign m_axi.rready  = rready_q;

  // Response IDs are not checked: only one transaction is ever in flight.
  logic unused_ids;
  assign unused_ids = ^{m_axi.rid, m_axi.bid};

endmodule

// File: tb/tb_axi_line_master.sv
module tb_axi_line_master;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int LW = 4;
  localparam int LB = LW * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LB-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic          resp_we;
  logic          resp_err;
  logic [LB-1:0] resp_rdata;

  always #5 clk = ~clk;

  axi_line_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) m ();

  axi_line_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LINE_WORDS(LW), .AXI_ID(8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_we_o(resp_we),
    .resp_err_o(resp_err), .resp_rdata_o(resp_rdata),
    .m_axi(m)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- RAM slave model ----------------
  logic [31:0]   mem [0:16383];
  int            s_last_beat = 3;
  int            s_err_beat = -1;
  logic [1:0]    s_bresp = 2'b00;
  bit            bp_en = 1'b0;
  logic [AW-1:0] s_exp_addr = '0;
  int            rd_base = 0, rd_beat = 0, wr_base = 0, wr_beat = 0;
  bit            rd_act = 0, aw_done = 0, b_pend = 0;
  bit            ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic          p_arvalid = 0, p_rready = 0, p_awvalid = 0, p_wvalid = 0, p_wlast = 0, p_bready = 0;
  logic [AW-1:0] p_araddr = '0, p_awaddr = '0;
  logic [DW-1:0] p_wdata = '0;

  task automatic slave_clear();
    m.arready = 0; m.rvalid = 0; m.rdata = '0; m.rresp = 2'b00; m.rlast = 0; m.rid = '0;
    m.awready = 0; m.wready = 0; m.bvalid = 0; m.bresp = 2'b00; m.bid = '0;
    rd_act = 0; rd_beat = 0; wr_beat = 0; aw_done = 0; b_pend = 0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    slave_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_clear();
      end else begin
        ar_hs = p_arvalid && m.arready;
        r_hs  = m.rvalid && p_rready;
        aw_hs = p_awvalid && m.awready;
        w_hs  = p_wvalid && m.wready;
        b_hs  = m.bvalid && p_bready;
        if (ar_hs) begin
          chk("araddr", LB'(p_araddr), LB'(s_exp_addr));
          chk("ar_ctrl", LB'({m.arlen, m.arsize, m.arburst, m.arid}), LB'({8'd3, 3'd2, 2'b01, 8'h00}));
          chk("ar_misc", LB'({m.arlock, m.arcache, m.arprot}), LB'(0));
          rd_base = int'(p_araddr >> 2); rd_beat = 0; rd_act = 1;
        end
        if (r_hs) begin
          rd_beat++;
          if (m.rlast) rd_act = 0;
        end
        if (w_hs) begin
          chk("w_after_aw", LB'(aw_done), LB'(1));
          chk("wlast", LB'(p_wlast), LB'(wr_beat == LW - 1));
          chk("wstrb", LB'(m.wstrb), LB'(4'hF));
          mem[(wr_base + wr_beat) & 16383] = p_wdata;
          wr_beat++;
          if (p_wlast) begin b_pend = 1; aw_done = 0; end
        end
        if (aw_hs) begin
          chk("awaddr", LB'(p_awaddr), LB'(s_exp_addr));
          chk("aw_ctrl", LB'({m.awlen, m.awsize, m.awburst, m.awid}), LB'({8'd3, 3'd2, 2'b01, 8'h00}));
          wr_base = int'(p_awaddr >> 2); wr_beat = 0; aw_done = 1;
        end
        if (b_hs) b_pend = 0;
        if (p_wvalid && !w_hs) begin
          chk("wvalid_held", LB'(m.wvalid), LB'(1));
          chk("wdata_stable", LB'({m.wlast, m.wdata}), LB'({p_wlast, p_wdata}));
        end
        if (p_arvalid && !ar_hs) chk("araddr_stable", LB'({m.arvalid, m.araddr}), LB'({1'b1, p_araddr}));
        if (p_awvalid && !aw_hs) chk("awaddr_stable", LB'({m.awvalid, m.awaddr}), LB'({1'b1, p_awaddr}));
        m.arready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        m.awready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        m.wready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!m.rvalid || r_hs) begin
          if (rd_act && (!bp_en || $urandom_range(0, 2) != 0)) begin
            m.rvalid = 1;
            m.rdata  = mem[(rd_base + rd_beat) & 16383];
            m.rresp  = (rd_beat == s_err_beat) ? 2'b10 : 2'b00;
            m.rlast  = (rd_beat == s_last_beat);
          end else begin
            m.rvalid = 0;
            m.rlast  = 0;
          end
        end
        m.bvalid = b_pend;
        m.bresp  = s_bresp;
      end
      p_arvalid = m.arvalid; p_araddr = m.araddr; p_rready = m.rready;
      p_awvalid = m.awvalid; p_awaddr = m.awaddr;
      p_wvalid = m.wvalid; p_wdata = m.wdata; p_wlast = m.wlast; p_bready = m.bready;
    end
  end

  // ---------------- request driver ----------------
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [LB-1:0] wl,
                        input logic [AW-1:0] exp_addr, input int hold,
                        output logic [LB-1:0] rd, output logic er, output logic ewe);
    int n;
    s_exp_addr = exp_addr;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("req_ready", LB'(req_ready), LB'(1));
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wl;
    resp_ready = (hold == 0);
    @(negedge clk); #1;
    req_valid = 0;
    chk("first_valid", LB'(we ? m.awvalid : m.arvalid), LB'(1));
    n = 0;
    while (!resp_valid && n < 400) begin @(negedge clk); #1; n++; end
    chk("resp_timeout", LB'(resp_valid), LB'(1));
    rd = resp_rdata; er = resp_err; ewe = resp_we;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk("resp_held", LB'(resp_valid), LB'(1));
      chk("rdata_held", resp_rdata, rd);
    end
    resp_ready = 1;
    @(negedge clk); #1;
    chk("back_idle", LB'({resp_valid, req_ready}), LB'(2'b01));
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LB-1:0] wline;
    int            last_beat;
    int            err_beat;
    logic [1:0]    bresp;
    logic [AW-1:0] exp_addr;
    logic [LB-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LB-1:0] rd;
    logic er, ewe;
    int n;

    vecs[0] = '{1'b0, 16'h0104, '0, 3, -1, 2'b00, 16'h0100,
                {32'hC0DE0043, 32'hC0DE0042, 32'hC0DE0041, 32'hC0DE0040}, 1'b0};
    vecs[1] = '{1'b1, 16'h0200, {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000},
                3, -1, 2'b00, 16'h0200,
                {32'hC0DE0043, 32'hC0DE0042, 32'hC0DE0041, 32'hC0DE0040}, 1'b0};
    vecs[2] = '{1'b0, 16'h0200, '0, 3, -1, 2'b00, 16'h0200,
                {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000}, 1'b0};
    vecs[3] = '{1'b0, 16'h0300, '0, 3, 1, 2'b00, 16'h0300,
                {32'hC0DE00C3, 32'hC0DE00C2, 32'hC0DE00C1, 32'hC0DE00C0}, 1'b1};
    vecs[4] = '{1'b0, 16'h0310, '0, 3, -1, 2'b00, 16'h0310,
                {32'hC0DE00C7, 32'hC0DE00C6, 32'hC0DE00C5, 32'hC0DE00C4}, 1'b0};
    vecs[5] = '{1'b0, 16'h0400, '0, 2, -1, 2'b00, 16'h0400,
                {32'hC0DE00C7, 32'hC0DE0102, 32'hC0DE0101, 32'hC0DE0100}, 1'b1};
    vecs[6] = '{1'b1, 16'h0500, {32'hEEEE0003, 32'hEEEE0002, 32'hEEEE0001, 32'hEEEE0000},
                3, -1, 2'b10, 16'h0500,
                {32'hC0DE00C7, 32'hC0DE0102, 32'hC0DE0101, 32'hC0DE0100}, 1'b1};
    vecs[7] = '{1'b0, 16'h050C, '0, 3, -1, 2'b00, 16'h0500,
                {32'hEEEE0003, 32'hEEEE0002, 32'hEEEE0001, 32'hEEEE0000}, 1'b0};
    vecs[8] = '{1'b0, 16'h0600, '0, 5, -1, 2'b00, 16'h0600,
                {32'hC0DE0185, 32'hC0DE0182, 32'hC0DE0181, 32'hC0DE0180}, 1'b1};

    rst = 1;
    repeat (3) @(negedge clk);
    #1 rst = 0;
    @(negedge clk); #1;
    chk("rst_req_ready", LB'(req_ready), LB'(1));
    chk("rst_valids", LB'({m.arvalid, m.awvalid, m.wvalid, m.bready, m.rready, resp_valid}), LB'(0));
    chk("rst_err", LB'(resp_err), LB'(0));
    chk("rst_rdata", resp_rdata, LB'(0));

    for (int i = 0; i < 9; i++) begin
      s_last_beat = vecs[i].last_beat;
      s_err_beat  = vecs[i].err_beat;
      s_bresp     = vecs[i].bresp;
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wline, vecs[i].exp_addr, 0, rd, er, ewe);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), LB'(er), LB'(vecs[i].exp_err));
      chk($sformatf("v%0d_we", i), LB'(ewe), LB'(vecs[i].we));
    end
    s_last_beat = 3; s_err_beat = -1; s_bresp = 2'b00;

    // random slave gaps plus a requester that stalls the completion
    bp_en = 1;
    do_req(1'b1, 16'h0700, {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000},
           16'h0700, 0, rd, er, ewe);
    chk("bp_wb_err", LB'(er), LB'(0));
    do_req(1'b0, 16'h0708, '0, 16'h0700, 5, rd, er, ewe);
    chk("bp_fill_rdata", rd, {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000});
    chk("bp_fill_err", LB'(er), LB'(0));
    bp_en = 0;

    // reset while the third W beat is pending
    s_exp_addr = 16'h0800;
    req_valid = 1; req_we = 1; req_addr = 16'h0800;
    req_wdata = {32'h66660003, 32'h66660002, 32'h66660001, 32'h66660000};
    @(negedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!(m.wvalid && wr_beat == 2) && n < 50) begin @(negedge clk); #1; n++; end
    chk("reach_w2", LB'(m.wvalid && wr_beat == 2), LB'(1));
    rst = 1;
    @(negedge clk); #1;
    chk("mid_rst_valids", LB'({m.arvalid, m.awvalid, m.wvalid, m.bready, m.rready, resp_valid}), LB'(0));
    chk("mid_rst_ready", LB'(req_ready), LB'(1));
    chk("mid_rst_rdata", resp_rdata, LB'(0));
    rst = 0;
    @(negedge clk); #1;
    do_req(1'b0, 16'h0800, '0, 16'h0800, 0, rd, er, ewe);
    chk("post_rst_rdata", rd, {32'hC0DE0203, 32'hC0DE0202, 32'h66660001, 32'h66660000});
    chk("post_rst_err", LB'(er), LB'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
